vga_scan_out: RTL and testbench
===============================

# vga_scan_out

Display-side timing generator and pixel scan-out for the edge-detect pipeline. It produces the `hcount`/`vcount` raster that drives the upstream pixel path, including the half-resolution Sobel stage. It then takes the 12-bit pixel that path returns a fixed number of cycles later and drives it to the VGA pins. Sync and blanking are delayed internally so that colour, `vga_hs` and `vga_vs` leave the block cycle-aligned, at 800x600@60 SVGA timing on a 40 MHz pixel clock.

## Interface
- `H_ADDR`, 800: active pixels per line.
- `H_FP`, 40: horizontal front porch, in clocks.
- `H_SYNC`, 128: horizontal sync width, in clocks.
- `H_BP`, 88: horizontal back porch, in clocks.
- `V_ADDR`, 600: active lines per frame.
- `V_FP`, 1: vertical front porch, in lines.
- `V_SYNC`, 4: vertical sync width, in lines.
- `V_BP`, 23: vertical back porch, in lines.
- `PIPE_DELAY`, 4: clocks from `hcount`/`vcount` to the matching `pixel_in`. Legal range is 1..15.
- `BORDER`, 0: when 1, the outermost active row and column are forced white.
- `clk  input  1`: pixel clock.
- `rst  input  1`: reset, asynchronous, active-low.
- `hcount  output  11`: horizontal raster counter.
- `vcount  output  11`: vertical raster counter.
- `frame_start  output  1`: one-clock pulse at raster position (0,0).
- `pixel_in  input  12`: {R[11:8], G[7:4], B[3:0]} for the position issued `PIPE_DELAY` clocks earlier.
- `vga_r`, `vga_g`, `vga_b  output  4 each`: colour outputs, registered.
- `vga_hs`, `vga_vs  output  1 each`: syncs, registered, active-high.

## Operation
- Derived totals: `H_TOTAL = H_ADDR+H_FP+H_SYNC+H_BP` (1056); `V_TOTAL` (628).
- `hcount` increments by 1 every clock.
  - At `H_TOTAL-1` it wraps to 0 and `vcount` increments.
  - `vcount` wraps from `V_TOTAL-1` to 0 on the clock where `hcount` also wraps.
  - Both are registers; no other value is ever produced.
- Decodes from the current counters:
  - active = `hcount<H_ADDR && vcount<V_ADDR`.
  - hs_raw = `hcount` in [`H_ADDR+H_FP`, `H_ADDR+H_FP+H_SYNC-1`], i.e. 840..967.
  - vs_raw = `vcount` in [`V_ADDR+V_FP`, `V_ADDR+V_FP+V_SYNC-1`], i.e. 601..604.
  - edge = active and (`hcount`==0, `hcount`==`H_ADDR-1`, `vcount`==0, or `vcount`==`V_ADDR-1`).
- {active, hs_raw, vs_raw, edge} enter a `PIPE_DELAY`-deep shift register. Its output stage is aligned with `pixel_in`.
- Output register, loaded every clock:
  - Colour = 12'hFFF if delayed active, delayed edge and `BORDER`==1.
  - Else colour = `pixel_in` if delayed active.
  - Else colour = 0.
  - `vga_hs`/`vga_vs` load the delayed hs_raw/vs_raw.
- `frame_start` = (`hcount`==0 && `vcount`==0), decoded from the counter registers. It is forced low while `rst` is asserted.
- `pixel_in` is ignored whenever delayed active is 0: colour is exactly 0 in blanking, whatever value is presented.

## Timing
- Reset (`rst`=0, asynchronous):
  - `hcount`=0, `vcount`=0.
  - All delay-line stages cleared to 0.
  - `vga_r`/`vga_g`/`vga_b`=0, `vga_hs`=0, `vga_vs`=0, `frame_start`=0.
- First rising edge after release: `hcount` goes 0->1. `frame_start` is high for exactly the one cycle between release and that edge.
- Latency:
  - Colour and syncs for counter position (h,v) appear on the pins `PIPE_DELAY+1` clocks after `hcount`=h, `vcount`=v.
  - Default: 5 clocks.
  - Sync pulse widths are unchanged by the delay.
- For the first `PIPE_DELAY+1` clocks after reset, pins show blank: colour 0, syncs 0. Stale or uninitialised data never reaches the pins.
- Reset mid-line or mid-frame:
  - Takes effect immediately; no drain of the delay line.
  - The raster restarts at (0,0) with a fresh `frame_start`.
- Wrap coincidence: at (1055,627) the next clock gives (0,0) and `frame_start`=1. No intermediate (0,628) or (1056,x) state ever exists.
- Frame period: exactly `H_TOTAL*V_TOTAL` = 663,168 clocks between `frame_start` pulses.

## Test plan
- Reset and free-run 2 frames:
  - `frame_start` pulses are exactly 663,168 clocks apart.
  - `hcount` max 1055, `vcount` max 627.
- Sync alignment, `pixel_in`=12'hABC constant, `PIPE_DELAY`=4:
  - `vga_hs` rises 5 clocks after `hcount`=840 and stays high 128 clocks.
  - `vga_vs` is high for 4 lines, starting 5 clocks after (0,601).
- Pixel alignment, `pixel_in` driven as a function of the position issued 4 clocks earlier, {h[3:0],v[3:0],4'h5}:
  - At the pins, position (h,v) shows exactly that pattern.
  - Colour is 0 at h=800..1055 and for v>=600 while `pixel_in` is nonzero.
- `BORDER`=1, `pixel_in`=12'h000:
  - Colour is FFF at (0,0), (799,10), (10,599) and (799,599).
  - Colour is 000 at (1,1) and (400,300).
- Reset pulse asserted at (500,300) for 3 clocks:
  - Outputs go to 0 asynchronously, before the next edge.
  - After release: `hcount`=0, `vcount`=0, `frame_start`=1, and the first nonzero colour appears only after the 5-clock latency.
- Back-to-back frames with `pixel_in` randomised:
  - `vga_hs`/`vga_vs` never glitch.
  - Colour is never nonzero while `vga_hs` or `vga_vs` is high.

Source files
------------

// File: rtl/vga_scan_out.sv
// Raster timing generator and pixel scan-out: issues hcount/vcount upstream and
// drives the returned pixel plus delayed sync/blanking to the VGA pins, cycle-aligned.
module vga_scan_out #(
   parameter int unsigned H_ADDR     = 800,
   parameter int unsigned H_FP       = 40,
   parameter int unsigned H_SYNC     = 128,
   parameter int unsigned H_BP       = 88,
   parameter int unsigned V_ADDR     = 600,
   parameter int unsigned V_FP       = 1,
   parameter int unsigned V_SYNC     = 4,
   parameter int unsigned V_BP       = 23,
   parameter int unsigned PIPE_DELAY = 4,
   parameter bit          BORDER     = 1'b0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] hcount,
   output logic [10:0] vcount,
   output logic        frame_start,
   input  logic [11:0] pixel_in,
   output logic [3:0]  vga_r,
   output logic [3:0]  vga_g,
   output logic [3:0]  vga_b,
   output logic        vga_hs,
   output logic        vga_vs
);

   localparam int unsigned CW       = 11;
   localparam int unsigned H_TOTAL  = H_ADDR + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL  = V_ADDR + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_START = H_ADDR + H_FP;
   localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
   localparam int unsigned VS_START = V_ADDR + V_FP;
   localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

   typedef struct packed {
      logic active;
      logic hs;
      logic vs;
      logic brd;
   } tag_t;

   tag_t        tag_c;
   tag_t        dly [PIPE_DELAY];
   tag_t        tap;
   logic [11:0] colour_c;

   // Raster counters; vcount advances only on the hcount wrap.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hcount <= '0;
         vcount <= '0;
      end else if (hcount == CW'(H_TOTAL - 1)) begin
         hcount <= '0;
         vcount <= (vcount == CW'(V_TOTAL - 1)) ? '0 : vcount + CW'(1);
      end else begin
         hcount <= hcount + CW'(1);
      end
   end

   always_comb begin
      tag_c        = '0;
      tag_c.active = (hcount < CW'(H_ADDR)) && (vcount < CW'(V_ADDR));
      tag_c.hs     = (hcount >= CW'(HS_START)) && (hcount <= CW'(HS_END));
      tag_c.vs     = (vcount >= CW'(VS_START)) && (vcount <= CW'(VS_END));
      tag_c.brd    = tag_c.active &&
                     ((hcount == '0) || (hcount == CW'(H_ADDR - 1)) ||
                      (vcount == '0) || (vcount == CW'(V_ADDR - 1)));
   end

   // Tag delay line; the last stage lines up with pixel_in.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < PIPE_DELAY; i++) dly[i] <= '0;
      end else begin
         dly[0] <= tag_c;
         for (int i = 1; i < PIPE_DELAY; i++) dly[i] <= dly[i-1];
      end
   end

   assign tap = dly[PIPE_DELAY-1];

   always_comb begin
      colour_c = 12'h000;
      if (tap.active) begin
         colour_c = (BORDER && tap.brd) ? 12'hFFF : pixel_in;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vga_r  <= '0;
         vga_g  <= '0;
         vga_b  <= '0;
         vga_hs <= 1'b0;
         vga_vs <= 1'b0;
      end else begin
         vga_r  <= colour_c[11:8];
         vga_g  <= colour_c[7:4];
         vga_b  <= colour_c[3:0];
         vga_hs <= tap.hs;
         vga_vs <= tap.vs;
      end
   end

   // Held low during reset so the (0,0) counter state cannot pulse early.
   assign frame_start = rst && (hcount == '0) && (vcount == '0);

endmodule

// File: tb/tb_vga_scan_out.sv
// Scoreboarded bench for vga_scan_out on a reduced raster, plus a BORDER=1 instance.
module tb_vga_scan_out;

   localparam int H_ADDR = 16, H_FP = 3, H_SYNC = 5, H_BP = 4;
   localparam int V_ADDR = 10, V_FP = 1, V_SYNC = 3, V_BP = 2;
   localparam int PD = 4;
   localparam int H_TOTAL = H_ADDR + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ADDR + V_FP + V_SYNC + V_BP;
   localparam int FRAME = H_TOTAL * V_TOTAL;
   localparam int NVEC = 6;

   logic        clk, rst;
   logic [11:0] pix1, pix2;
   logic [10:0] hc1, vc1, hc2, vc2;
   logic        fs1, fs2, hs1, vs1, hs2, vs2;
   logic [3:0]  r1, g1, b1, r2, g2, b2;

   vga_scan_out #(.H_ADDR(H_ADDR), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                  .V_ADDR(V_ADDR), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                  .PIPE_DELAY(PD), .BORDER(1'b0)) dut (
      .clk(clk), .rst(rst), .hcount(hc1), .vcount(vc1), .frame_start(fs1),
      .pixel_in(pix1), .vga_r(r1), .vga_g(g1), .vga_b(b1), .vga_hs(hs1), .vga_vs(vs1));

   vga_scan_out #(.H_ADDR(H_ADDR), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
                  .V_ADDR(V_ADDR), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
                  .PIPE_DELAY(PD), .BORDER(1'b1)) dut_brd (
      .clk(clk), .rst(rst), .hcount(hc2), .vcount(vc2), .frame_start(fs2),
      .pixel_in(pix2), .vga_r(r2), .vga_g(g2), .vga_b(b2), .vga_hs(hs2), .vga_vs(vs2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          valid;
      int          h;
      int          v;
      logic [13:0] out;
   } exp_t;

   typedef struct {
      int          h;
      int          v;
      logic [11:0] col;
   } vec_t;

   exp_t        exp_q[$];
   logic [11:0] pix_q[$];
   vec_t        vt[NVEC];
   bit          seen[NVEC];

   int checks, errors;
   int mh, mv, cyc, last_fs, hs_run, vs_run, hmax, vmax, pmode;

   // Expected pins {colour, hs, vs} for position (h,v) carrying pixel pv.
   function automatic logic [13:0] out_of(int h, int v, logic [11:0] pv);
      logic active, hs, vs;
      active = (h < H_ADDR) && (v < V_ADDR);
      hs = (h >= H_ADDR + H_FP) && (h < H_ADDR + H_FP + H_SYNC);
      vs = (v >= V_ADDR + V_FP) && (v < V_ADDR + V_FP + V_SYNC);
      return {active ? pv : 12'h000, hs, vs};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d pos=(%0d,%0d): got %0h expected %0h",
                  name, cyc, mh, mv, act, exp);
      end
   endtask

   task automatic prime();
      exp_t b;
      exp_q.delete();
      pix_q.delete();
      b.valid = 1'b0; b.h = 0; b.v = 0; b.out = '0;
      for (int i = 0; i < PD + 1; i++) exp_q.push_back(b);
      for (int i = 0; i < PD; i++) pix_q.push_back(12'($urandom));
      mh = 0; mv = 0; cyc = 0; last_fs = -1; hs_run = 0; vs_run = 0;
   endtask

   // One clock: compare pins against the scoreboard, issue the next position.
   task automatic step();
      exp_t        e, n;
      logic [11:0] pv;
      logic        fs_exp;
      e = exp_q.pop_front();
      fs_exp = (mh == 0) && (mv == 0);
      check("pins", 32'({r1, g1, b1, hs1, vs1}), 32'(e.out));
      check("counters", 32'({hc1, vc1, fs1}), 32'({11'(mh), 11'(mv), fs_exp}));
      check("counters_brd", 32'({hc2, vc2, fs2}), 32'({11'(mh), 11'(mv), fs_exp}));
      check("sync_brd", 32'({hs2, vs2}), 32'(e.out[1:0]));
      if (e.valid) begin
         for (int i = 0; i < NVEC; i++) begin
            if (vt[i].h == e.h && vt[i].v == e.v) begin
               check("border_colour", 32'({r2, g2, b2}), 32'(vt[i].col));
               seen[i] = 1'b1;
            end
         end
      end
      if (hs1 || vs1) check("blank_in_sync", 32'({r1, g1, b1}), 32'h0);
      if (hs1) hs_run++;
      else if (hs_run > 0) begin
         check("hs_width", 32'(hs_run), 32'(H_SYNC));
         hs_run = 0;
      end
      if (vs1) vs_run++;
      else if (vs_run > 0) begin
         check("vs_width", 32'(vs_run), 32'(V_SYNC * H_TOTAL));
         vs_run = 0;
      end
      if (fs1) begin
         if (last_fs >= 0) check("frame_period", 32'(cyc - last_fs), 32'(FRAME));
         last_fs = cyc;
      end
      if (int'(hc1) > hmax) hmax = int'(hc1);
      if (int'(vc1) > vmax) vmax = int'(vc1);
      pv = (pmode == 0) ? {4'(mh), 4'(mv), 4'h5} : 12'($urandom);
      pix_q.push_back(pv);
      pix1 = pix_q.pop_front();
      n.valid = 1'b1; n.h = mh; n.v = mv; n.out = out_of(mh, mv, pv);
      exp_q.push_back(n);
      if (mh == H_TOTAL - 1) begin
         mh = 0;
         mv = (mv == V_TOTAL - 1) ? 0 : mv + 1;
      end else begin
         mh++;
      end
      cyc++;
      @(negedge clk);
   endtask

   initial begin
      int nseen;
      checks = 0; errors = 0; hmax = 0; vmax = 0; pmode = 0;
      vt[0] = '{0, 0, 12'hFFF};
      vt[1] = '{H_ADDR - 1, 3, 12'hFFF};
      vt[2] = '{3, V_ADDR - 1, 12'hFFF};
      vt[3] = '{H_ADDR - 1, V_ADDR - 1, 12'hFFF};
      vt[4] = '{1, 1, 12'h000};
      vt[5] = '{H_ADDR / 2, V_ADDR / 2, 12'h000};
      for (int i = 0; i < NVEC; i++) seen[i] = 1'b0;
      rst = 1'b0; pix1 = 12'hABC; pix2 = 12'h000;
      mh = 0; mv = 0; cyc = 0;

      #12;
      check("reset_pins", 32'({r1, g1, b1, hs1, vs1}), 32'h0);
      check("reset_cnt", 32'({hc1, vc1, fs1}), 32'h0);
      check("reset_cnt_brd", 32'({hc2, vc2, fs2, r2, g2, b2}), 32'h0);

      @(negedge clk);
      rst = 1'b1;
      prime();
      #1;
      check("release_fs", 32'({hc1, vc1, fs1}), 32'h1);
      for (int k = 0; k < FRAME; k++) step();
      pmode = 1;
      for (int k = 0; k < FRAME + 10; k++) step();
      check("hcount_max", 32'(hmax), 32'(H_TOTAL - 1));
      check("vcount_max", 32'(vmax), 32'(V_TOTAL - 1));

      // Mid-frame reset at (H_ADDR/2, V_ADDR/2).
      pmode = 0;
      for (int k = 0; k < 2 * FRAME && !(mh == H_ADDR / 2 && mv == V_ADDR / 2); k++) step();
      check("seek_reset_pos", 32'({hc1, vc1}), 32'({11'(H_ADDR / 2), 11'(V_ADDR / 2)}));
      check("pre_reset_colour", 32'({r1, g1, b1} != 12'h0), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_pins", 32'({r1, g1, b1, hs1, vs1}), 32'h0);
      check("async_cnt", 32'({hc1, vc1, fs1}), 32'h0);
      repeat (3) @(posedge clk);
      #1;
      check("held_reset", 32'({hc1, vc1, fs1, r1, g1, b1}), 32'h0);
      @(negedge clk);
      rst = 1'b1;
      prime();
      #1;
      check("rerelease", 32'({hc1, vc1, fs1}), 32'h1);
      for (int k = 0; k < FRAME + 20; k++) step();

      nseen = 0;
      for (int i = 0; i < NVEC; i++) nseen += int'(seen[i]);
      check("table_seen", 32'(nseen), 32'(NVEC));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
